seg7_multi_display: RTL

//  Parametrised N-digit hex 7-segment display controller, Avalon-style write port.

---
 rtl/seg7_multi_display_if.sv | 10 +
 rtl/seg7_multi_display.sv | 107 ++++++++++
 2 files changed

// File: rtl/seg7_multi_display_if.sv
// Write-only register bus between the Nios II slave port and the display controller.
// iWR acts as valid; the controller is always ready, so every cycle with iWR high is one write.
interface seg7_multi_display_if;
   logic        iWR;
   logic [1:0]  iADDR;
   logic [31:0] iWDATA;

   modport master (output iWR, iADDR, iWDATA);
   modport slave  (input  iWR, iADDR, iWDATA);
endinterface

// File: rtl/seg7_multi_display.sv
// N-digit hex 7-segment controller: digit/blank/blink/control registers, a blink
// timer and one registered stage of segment decode with selectable polarity.
module seg7_multi_display #(
   parameter int NUM_DIGITS = 8,
   parameter int BLINK_DIV  = 25_000_000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                    iCLK,
   input  logic                    iRST_N,
   seg7_multi_display_if.slave     bus,
   output logic [7*NUM_DIGITS-1:0] oSEG,
   output logic                    oPHASE
);
   localparam int             CntW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(BLINK_DIV - 1);
   localparam logic [6:0]     OffPat  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

   logic [4*NUM_DIGITS-1:0] digReg;
   logic [NUM_DIGITS-1:0]   blankReg;
   logic [NUM_DIGITS-1:0]   blinkReg;
   logic                    enReg;
   logic                    benReg;
   logic [CntW-1:0]         cnt;
   logic [7*NUM_DIGITS-1:0] segNext;
   logic                    benClear;

   // A control write dropping BEN must beat a wrap happening on the same edge.
   assign benClear = bus.iWR && (bus.iADDR == 2'd3) && !bus.iWDATA[1];

   function automatic logic [6:0] hexDecode(input logic [3:0] nib);
      logic [6:0] pat;
      pat = 7'h7F;
      case (nib)
         4'h0: pat = 7'h40;
         4'h1: pat = 7'h79;
         4'h2: pat = 7'h24;
         4'h3: pat = 7'h30;
         4'h4: pat = 7'h19;
         4'h5: pat = 7'h12;
         4'h6: pat = 7'h02;
         4'h7: pat = 7'h78;
         4'h8: pat = 7'h00;
         4'h9: pat = 7'h10;
         4'hA: pat = 7'h08;
         4'hB: pat = 7'h03;
         4'hC: pat = 7'h46;
         4'hD: pat = 7'h21;
         4'hE: pat = 7'h06;
         4'hF: pat = 7'h0E;
         default: pat = 7'h7F;
      endcase
      return pat;
   endfunction

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         digReg   <= '0;
         blankReg <= '0;
         blinkReg <= '0;
         enReg    <= 1'b0;
         benReg   <= 1'b0;
      end else if (bus.iWR) begin
         case (bus.iADDR)
            2'd0: digReg   <= bus.iWDATA[4*NUM_DIGITS-1:0];
            2'd1: blankReg <= bus.iWDATA[NUM_DIGITS-1:0];
            2'd2: blinkReg <= bus.iWDATA[NUM_DIGITS-1:0];
            default: begin
               enReg  <= bus.iWDATA[0];
               benReg <= bus.iWDATA[1];
            end
         endcase
      end
   end

   // Blink timer; setting BEN from 0 leaves CNT at 0 on the write edge itself.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         cnt    <= '0;
         oPHASE <= 1'b0;
      end else if (benClear || !benReg) begin
         cnt    <= '0;
         oPHASE <= 1'b0;
      end else if (cnt == CntLast) begin
         cnt    <= '0;
         oPHASE <= ~oPHASE;
      end else begin
         cnt <= cnt + CntW'(1);
      end
   end

   always_comb begin
      segNext = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!enReg || blankReg[i] || (blinkReg[i] && benReg && oPHASE))
            segNext[7*i +: 7] = OffPat;
         else if (ACTIVE_LOW != 0)
            segNext[7*i +: 7] = hexDecode(digReg[4*i +: 4]);
         else
            segNext[7*i +: 7] = ~hexDecode(digReg[4*i +: 4]);
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) oSEG <= {NUM_DIGITS{OffPat}};
      else         oSEG <= segNext;
   end
endmodule
